// File: rtl/demux1to24_collector.sv
// demux1to24_collector: scatters tagged words into 24 registered lanes and holds each full frame until it is acknowledged.
module demux1to24_collector #(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [4:0]            in_sel,
  output logic [DATA_WIDTH-1:0] out0,
  output logic [DATA_WIDTH-1:0] out1,
  output logic [DATA_WIDTH-1:0] out2,
  output logic [DATA_WIDTH-1:0] out3,
  output logic [DATA_WIDTH-1:0] out4,
  output logic [DATA_WIDTH-1:0] out5,
  output logic [DATA_WIDTH-1:0] out6,
  output logic [DATA_WIDTH-1:0] out7,
  output logic [DATA_WIDTH-1:0] out8,
  output logic [DATA_WIDTH-1:0] out9,
  output logic [DATA_WIDTH-1:0] out10,
  output logic [DATA_WIDTH-1:0] out11,
  output logic [DATA_WIDTH-1:0] out12,
  output logic [DATA_WIDTH-1:0] out13,
  output logic [DATA_WIDTH-1:0] out14,
  output logic [DATA_WIDTH-1:0] out15,
  output logic [DATA_WIDTH-1:0] out16,
  output logic [DATA_WIDTH-1:0] out17,
  output logic [DATA_WIDTH-1:0] out18,
  output logic [DATA_WIDTH-1:0] out19,
  output logic [DATA_WIDTH-1:0] out20,
  output logic [DATA_WIDTH-1:0] out21,
  output logic [DATA_WIDTH-1:0] out22,
  output logic [DATA_WIDTH-1:0] out23,
  output logic [23:0]           fill_mask,
  output logic                  out_valid,
  input  logic                  out_ack,
  output logic                  frame_done,
  output logic                  sel_err
);
  typedef enum logic {FILL, HOLD} state_t;
  state_t state, state_n;
  logic xfer, wr, done;
  logic [23:0] mask_n;
  logic [DATA_WIDTH-1:0] lanes [24];
  assign in_ready = state == FILL && !reset;
  assign out_valid = state == HOLD;
  // clear wins over any simultaneous write or completion
  always_comb begin
    xfer = in_valid && in_ready;
    wr = xfer && !clear && in_sel < 5'd24;
    mask_n = fill_mask | (wr ? 24'd1 << in_sel : 24'd0);
    done = wr && &mask_n;
    state_n = clear ? FILL : state == FILL ? (done ? HOLD : FILL) : (out_ack ? FILL : HOLD);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
      fill_mask <= '0;
      frame_done <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      state <= state_n;
      fill_mask <= (clear || (state == HOLD && out_ack)) ? '0 : mask_n;
      frame_done <= done;
      sel_err <= xfer && !clear && in_sel >= 5'd24 && in_sel <= 5'd30;
    end
  end
  for (genvar i = 0; i < 24; i++) begin : g_lane
    always_ff @(posedge clk) begin
      if (reset) lanes[i] <= '0;
      else if (wr && in_sel == 5'(i)) lanes[i] <= in_data;
    end
  end
  assign out0 = lanes[0];   assign out1 = lanes[1];   assign out2 = lanes[2];   assign out3 = lanes[3];
  assign out4 = lanes[4];   assign out5 = lanes[5];   assign out6 = lanes[6];   assign out7 = lanes[7];
  assign out8 = lanes[8];   assign out9 = lanes[9];   assign out10 = lanes[10]; assign out11 = lanes[11];
  assign out12 = lanes[12]; assign out13 = lanes[13]; assign out14 = lanes[14]; assign out15 = lanes[15];
  assign out16 = lanes[16]; assign out17 = lanes[17]; assign out18 = lanes[18]; assign out19 = lanes[19];
  assign out20 = lanes[20]; assign out21 = lanes[21]; assign out22 = lanes[22]; assign out23 = lanes[23];
endmodule

// File: tb/tb_demux1to24_collector.sv
// tb_demux1to24_collector: directed stimulus checked every cycle against a frame-level model, plus literal spot checks.
module tb_demux1to24_collector;
  logic clk = 1'b0, reset = 1'b1, clear = 1'b0, in_valid = 1'b0, out_ack = 1'b0;
  logic [11:0] in_data = '0;
  logic [4:0] in_sel = '0;
  logic in_ready, out_valid, frame_done, sel_err;
  logic [23:0] fill_mask;
  logic [11:0] out0, out1, out2, out3, out4, out5, out6, out7, out8, out9, out10, out11;
  logic [11:0] out12, out13, out14, out15, out16, out17, out18, out19, out20, out21, out22, out23;
  logic [24*12-1:0] dl;
  int n_cmp = 0, n_bad = 0;
  bit started = 0;
  logic [11:0] m_lane [24];
  logic [23:0] m_mask = '0;
  bit m_hold = 0, m_fd = 0, m_se = 0;

  always #5 clk = ~clk;

  demux1to24_collector #(.DATA_WIDTH(12)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3), .out4(out4), .out5(out5),
    .out6(out6), .out7(out7), .out8(out8), .out9(out9), .out10(out10), .out11(out11),
    .out12(out12), .out13(out13), .out14(out14), .out15(out15), .out16(out16), .out17(out17),
    .out18(out18), .out19(out19), .out20(out20), .out21(out21), .out22(out22), .out23(out23),
    .fill_mask(fill_mask), .out_valid(out_valid), .out_ack(out_ack),
    .frame_done(frame_done), .sel_err(sel_err));

  assign dl = {out23, out22, out21, out20, out19, out18, out17, out16, out15, out14, out13, out12,
               out11, out10, out9, out8, out7, out6, out5, out4, out3, out2, out1, out0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: what each accepted word must do to lanes, mask and flags.
  always @(posedge clk) begin
    m_fd = 0;
    m_se = 0;
    if (reset) begin
      foreach (m_lane[i]) m_lane[i] = '0;
      m_mask = '0;
      m_hold = 0;
    end else if (clear) begin
      m_mask = '0;
      m_hold = 0;
    end else if (m_hold) begin
      if (out_ack) begin
        m_hold = 0;
        m_mask = '0;
      end
    end else if (in_valid) begin
      if (in_sel < 24) begin
        m_lane[in_sel] = in_data;
        m_mask = m_mask | (24'd1 << in_sel);
        if (m_mask == 24'hFFFFFF) begin
          m_hold = 1;
          m_fd = 1;
        end
      end else if (in_sel != 31) m_se = 1;
    end
  end

  always @(negedge clk) if (started) begin
    for (int i = 0; i < 24; i++) chk($sformatf("lane%0d", i), 32'(dl[i*12 +: 12]), 32'(m_lane[i]));
    chk("fill_mask", 32'(fill_mask), 32'(m_mask));
    chk("out_valid", 32'(out_valid), 32'(m_hold));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("sel_err", 32'(sel_err), 32'(m_se));
    chk("in_ready", 32'(in_ready), 32'(!m_hold && !reset));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int sel, input int data);
    in_valid = 1;
    in_sel = 5'(sel);
    in_data = 12'(data);
    step();
  endtask

  int perm [24];

  initial begin
    step();
    started = 1;
    step();
    chk("reset_mask", 32'(fill_mask), 0);
    chk("reset_ready", 32'(in_ready), 0);
    chk("reset_lane0", 32'(out0), 0);
    reset = 0;
    // ordered fill
    for (int i = 0; i < 24; i++) send(i, 'h100 + i);
    in_valid = 0;
    chk("fill_valid", 32'(out_valid), 1);
    chk("fill_done", 32'(frame_done), 1);
    chk("fill_mask_full", 32'(fill_mask), 32'hFFFFFF);
    chk("fill_ready", 32'(in_ready), 0);
    chk("fill_out0", 32'(out0), 'h100);
    chk("fill_out23", 32'(out23), 'h117);
    chk("model_mask", 32'(m_mask), 32'hFFFFFF);
    // hold, then ack while the producer keeps offering
    for (int i = 0; i < 5; i++) send(3, 'h123);
    chk("hold_done_pulse", 32'(frame_done), 0);
    chk("hold_out3", 32'(out3), 'h103);
    out_ack = 1;
    step();
    out_ack = 0;
    chk("ack_valid", 32'(out_valid), 0);
    chk("ack_mask", 32'(fill_mask), 0);
    chk("ack_ready", 32'(in_ready), 1);
    step();
    in_valid = 0;
    chk("ack_out3", 32'(out3), 'h123);
    chk("ack_mask3", 32'(fill_mask), 'h8);
    // overwrite, null and illegal selects
    clear = 1;
    step();
    clear = 0;
    send(5, 'hAAA);
    send(5, 'h555);
    send(31, 'hFFF);
    chk("null_no_err", 32'(sel_err), 0);
    send(27, 'h0);
    in_valid = 0;
    chk("illegal_err", 32'(sel_err), 1);
    chk("ovr_out5", 32'(out5), 'h555);
    chk("ovr_mask", 32'(fill_mask), 'h20);
    chk("ovr_out4", 32'(out4), 'h104);
    step();
    chk("err_single", 32'(sel_err), 0);
    // clear beats completion
    clear = 1;
    step();
    clear = 0;
    for (int i = 0; i < 23; i++) send(i, 'h200 + i);
    clear = 1;
    send(23, 'h2FF);
    clear = 0;
    in_valid = 0;
    chk("clr_valid", 32'(out_valid), 0);
    chk("clr_done", 32'(frame_done), 0);
    chk("clr_mask", 32'(fill_mask), 0);
    chk("clr_out23", 32'(out23), 'h117);
    chk("clr_out22", 32'(out22), 'h216);
    // reset mid-frame
    for (int i = 0; i < 10; i++) send(i, 'h300 + i);
    in_valid = 0;
    reset = 1;
    #1;
    chk("rst_ready_low", 32'(in_ready), 0);
    step();
    reset = 0;
    #1;
    chk("rst_out9", 32'(out9), 0);
    chk("rst_mask", 32'(fill_mask), 0);
    chk("rst_ready_high", 32'(in_ready), 1);
    // backpressure with shuffled selects, a few lanes pre-written
    for (int i = 0; i < 6; i++) send(i, 'h400 + i);
    foreach (perm[i]) perm[i] = i;
    for (int i = 23; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int k = 0, budget = 0; k < 24 && budget < 2000; budget++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_sel = 5'(perm[k]);
      in_data = 12'($urandom);
      step();
      if (in_valid) k++;
      if (k < 24) chk("bp_not_early", 32'(out_valid), 0);
    end
    in_valid = 0;
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_done", 32'(frame_done), 1);
    out_ack = 1;
    step();
    out_ack = 0;
    step();
    started = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/demux1to24_collector.md
# demux1to24_collector

Sequential 1-to-24 scatter/collector: accepts a stream of DATA_WIDTH-bit words, each tagged with a 5-bit lane select, and writes each word into one of 24 registered output lanes. When all 24 lanes have been written, it freezes the frame, asserts `out_valid`, and waits for the consumer to acknowledge. It sits on the write side of the NPU datapath and fills the 24-input lane sets that downstream selection logic reads with the same 5-bit lane encoding. Select values 0–23 address lanes, and 31 is the null select.

## Interface
- DATA_WIDTH, 12, width of every data word and output lane
- clk  input  1  single clock; every register updates on its rising edge
- reset  input  1  synchronous, active-high; sampled on `clk`
- clear  input  1  synchronous frame abort; discards the fill mask and returns to FILL
- in_valid  input  1  producer has a word on `in_data`/`in_sel`
- in_ready  output  1  block can accept; a transfer occurs when `in_valid && in_ready` at a clock edge
- in_data  input  DATA_WIDTH  word to write
- in_sel  input  5  target lane 0–23; 24–30 illegal; 31 null
- out0 … out23  output  DATA_WIDTH each  registered lane contents
- fill_mask  output  24  bit i set when lane i has been written in the current frame
- out_valid  output  1  frame complete and held stable
- out_ack  input  1  consumer has taken the frame
- frame_done  output  1  one-cycle pulse on entry to HOLD
- sel_err  output  1  one-cycle pulse when an accepted word had `in_sel` in 24–30

## Operation
- States: FILL and HOLD. After reset the state is FILL.
- FILL:
  - `in_ready` = 1.
  - On a transfer with `in_sel` ≤ 23: `out[in_sel]` ← `in_data` and `fill_mask[in_sel]` ← 1.
  - Rewriting a lane that is already filled overwrites its data; the mask bit stays 1.
- Select 31: the word is accepted and dropped. No lane is written, no mask bit changes, and `sel_err` stays 0.
- Select 24–30: the word is accepted and dropped. No lane is written and `sel_err` = 1 for the following cycle.
- FILL → HOLD: when the mask including the current write equals 24'hFFFFFF. In the next cycle `out_valid` = 1 and `frame_done` = 1 for exactly that one cycle.
- HOLD:
  - `in_ready` = 0.
  - Lanes and mask are frozen.
  - `out_valid` stays 1 until `out_ack` is sampled high.
- HOLD → FILL on `out_ack`: on the next edge the mask is cleared and `out_valid` drops. Lane data is retained; it is not zeroed.
- `out_ack` in FILL: ignored.
- `clear`:
  - From any state, the next state is FILL, the mask is cleared, `out_valid` = 0 and there is no `frame_done` pulse. Lane data is retained.
  - `clear` beats a simultaneous transfer (the word is dropped, `sel_err` is not pulsed) and beats a simultaneous completion.
- `reset`: beats everything. All lanes = 0, mask = 0, state = FILL.
- Widths: data passes through unmodified, with no arithmetic. The mask update is an OR with the one-hot of `in_sel[4:0]`, gated to `in_sel` < 24.

## Timing
- Reset values: `out0`–`out23` = 0, `fill_mask` = 0, `out_valid` = 0, `frame_done` = 0, `sel_err` = 0.
- `in_ready` = 0 while `reset` is high. It is combinational from state: (state == FILL) && !reset.
- Write latency: a lane and its mask bit are updated and visible in the cycle after the transfer edge.
- Completion latency: `out_valid` and `frame_done` rise in the cycle after the transfer that completes the mask.
- Throughput: one word per cycle in FILL; a minimum of 24 transfers per frame.
- Release latency: `out_ack` sampled at edge N → `in_ready` = 1 in the cycle after edge N. The first new word can be accepted at edge N+1.
- `in_data`/`in_sel` are ignored when `in_valid` = 0 or `in_ready` = 0.
- Reset asserted mid-frame: all state is cleared at that edge and any partially filled frame is lost.

## Test plan
- Ordered fill:
  - Stimulus: after reset, send sel 0..23 with data 0x100+i, `in_valid` held high for 24 cycles.
  - Response: the cycle after the 24th transfer, `out_valid` = 1, `frame_done` pulses once, `out[i]` = 0x100+i, `fill_mask` = FFFFFF, `in_ready` = 0.
- Overwrite, null and illegal selects:
  - Stimulus: write lane 5 = 0xAAA, then lane 5 = 0x555, then sel 31 with data 0xFFF, then sel 27.
  - Response: `out5` = 0x555; only `fill_mask` bit 5 is set; `sel_err` pulses exactly once, after the sel 27 transfer; no other lane changes.
- Hold and ack:
  - Stimulus: complete a frame, keep `in_valid` high with sel 3 data 0x123 for 5 cycles, then assert `out_ack` for one cycle.
  - Response: `out3` is unchanged during HOLD; `out_valid` falls and the mask clears after the ack edge; the next edge accepts 0x123 into lane 3.
- Clear vs completion:
  - Stimulus: fill 23 lanes, then present the 24th word with `clear` = 1 in the same cycle.
  - Response: state FILL, mask 0, `out_valid` = 0, no `frame_done` pulse, lane 23 not written.
- Reset mid-operation:
  - Stimulus: fill 10 lanes, then pulse `reset` for one cycle.
  - Response: all lanes = 0, mask = 0, `in_ready` = 0 during the reset cycle and 1 afterward.
- Backpressure on the producer:
  - Stimulus: randomized `in_valid` gaps with a shuffled sel order 0–23.
  - Response: completion occurs exactly on the transfer that sets the final mask bit, and each lane holds the last value written to it.
